// File: rtl/cnt4_sched.sv
// Round-robin sequencer for a shared loadable up-counter: a load requester and an
// increment-burst requester take turns, and each granted operation runs to completion.
module cnt4_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_req,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_gnt,
  input  logic             inc_req,
  input  logic [WIDTH-1:0] inc_len,
  output logic             inc_gnt,
  output logic [WIDTH-1:0] cnt_q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // 1 when the load requester won the most recent arbitration
  logic             last_ld_q, last_ld_d;
  logic             tc_d, done_d;
  logic             idle;

  assign idle = (state_q == StIdle);
  assign busy = (state_q == StBurst);

  // On a tie the requester that did not win last time gets the grant.
  assign ld_gnt  = idle & ld_req  & (~inc_req | ~last_ld_q);
  assign inc_gnt = idle & inc_req & (~ld_req  |  last_ld_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    last_ld_d = last_ld_q;
    tc_d      = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_gnt) begin
          cnt_d     = ld_data;
          done_d    = 1'b1;
          last_ld_d = 1'b1;
        end else if (inc_gnt) begin
          rem_d     = inc_len;
          last_ld_d = 1'b0;
          if (inc_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StBurst;
          end
        end
      end
      StBurst: begin
        cnt_d = cnt_q + WIDTH'(1);
        rem_d = rem_q - WIDTH'(1);
        tc_d  = (cnt_q == '1);
        if (rem_q == WIDTH'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      last_ld_q <= 1'b0;
      tc        <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      last_ld_q <= last_ld_d;
      tc        <= tc_d;
      done      <= done_d;
    end
  end

endmodule
